// File: rtl/ppi_bus_controller_if.sv
// Bundle of the requester handshakes, status outputs and PPI pins used by
// ppi_bus_controller. "master" is the controller side, "slave" is the side
// made up of the two requesters and the PPI device.
interface ppi_bus_controller_if;
   // requester 0
   logic       req0;
   logic       we0;
   logic [1:0] addr0;
   logic [7:0] wdata0;
   logic       gnt0;
   logic       done0;
   // requester 1
   logic       req1;
   logic       we1;
   logic [1:0] addr1;
   logic [7:0] wdata1;
   logic       gnt1;
   logic       done1;
   // shared status
   logic [7:0] rdata;
   logic       busy;
   logic [7:0] cwr_shadow;
   // PPI pins
   logic       ppi_reset;
   logic       ppi_csb;
   logic       ppi_wrb;
   logic       ppi_rdb;
   logic       ppi_a1;
   logic       ppi_a0;
   logic [7:0] ppi_dout;
   logic       ppi_doe;
   logic [7:0] ppi_din;

   modport master (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ppi_din,
      output gnt0, done0, gnt1, done1,
      output rdata, busy, cwr_shadow,
      output ppi_reset, ppi_csb, ppi_wrb, ppi_rdb, ppi_a1, ppi_a0,
      output ppi_dout, ppi_doe
   );

   modport slave (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ppi_din,
      input  gnt0, done0, gnt1, done1,
      input  rdata, busy, cwr_shadow,
      input  ppi_reset, ppi_csb, ppi_wrb, ppi_rdb, ppi_a1, ppi_a0,
      input  ppi_dout, ppi_doe
   );
endinterface

// File: rtl/ppi_bus_controller.sv
// ppi_bus_controller: clocked bus master for an 8255-style PPI.
// Arbitrates two requesters round-robin, sequences SETUP/STROBE/HOLD bus
// cycles, pulses the PPI reset and writes INIT_CWR after every reset, and
// keeps a shadow of the last control word written.
// Optional feature macro: PPI_CWR_SKIP_EN -- a granted control-word write
// whose data equals the shadow skips the bus cycle (IDLE -> HOLD directly).
// Every output is a flop: the next-state logic computes the next state and
// fields, and the pin values are decoded from those and registered, so the
// visible pins always correspond to the current state.
module ppi_bus_controller #(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned RST_CYCLES    = 4,
   parameter logic [7:0]  INIT_CWR      = 8'h9B
) (
   input logic                  clk,
   input logic                  resetb,
   ppi_bus_controller_if.master bus
);

   typedef enum logic [2:0] {
      ST_INIT_RST = 3'd0,
      ST_INIT_CWR = 3'd1,
      ST_IDLE     = 3'd2,
      ST_SETUP    = 3'd3,
      ST_STROBE   = 3'd4,
      ST_HOLD     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OWN_INIT = 2'd0,
      OWN_REQ0 = 2'd1,
      OWN_REQ1 = 2'd2
   } owner_t;

   localparam int unsigned CNT_MAX = (STROBE_CYCLES > RST_CYCLES) ? STROBE_CYCLES : RST_CYCLES;
   localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [1:0]       ADDR_CWR    = 2'b11;

   // sequencing state
   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   owner_t           owner_r, owner_s;
   logic             we_r, we_s;
   logic [1:0]       addr_r, addr_s;
   logic [7:0]       wdata_r, wdata_s;
   logic             skip_r, skip_s;
   logic             rr_r, rr_s;
   logic [7:0]       rdata_r, rdata_s;
   logic [7:0]       shadow_r, shadow_s;
   logic             gnt0_r, gnt0_s;
   logic             gnt1_r, gnt1_s;

   // registered pin / status outputs
   logic             done0_r, done0_s;
   logic             done1_r, done1_s;
   logic             busy_r, busy_s;
   logic             ppi_reset_r, ppi_reset_s;
   logic             csb_r, csb_s;
   logic             wrb_r, wrb_s;
   logic             rdb_r, rdb_s;
   logic [1:0]       a_r, a_s;
   logic [7:0]       dout_r, dout_s;
   logic             doe_r, doe_s;

   // helpers
   logic             pick0_s, pick1_s;
   logic             arb_en_s;
   logic             skip_hit_s;
   logic             bus_act_s;

   // Round-robin choice between the two requesters (rr_r=0 favours req0).
   always_comb begin
      pick0_s = 1'b0;
      pick1_s = 1'b0;
      if (bus.req0 && bus.req1) begin
         pick0_s = ~rr_r;
         pick1_s = rr_r;
      end else if (bus.req0) begin
         pick0_s = 1'b1;
      end else if (bus.req1) begin
         pick1_s = 1'b1;
      end else begin
         pick0_s = 1'b0;
         pick1_s = 1'b0;
      end
   end

   // Detects a latched control-word write that would not change the PPI.
   always_comb begin
`ifdef PPI_CWR_SKIP_EN
      skip_hit_s = we_r && (addr_r == ADDR_CWR) && (wdata_r == shadow_r);
`else
      skip_hit_s = 1'b0;
`endif
   end

   // Next-state, field latching, read capture and shadow update.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      owner_s  = owner_r;
      we_s     = we_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      skip_s   = skip_r;
      rr_s     = rr_r;
      rdata_s  = rdata_r;
      shadow_s = shadow_r;
      gnt0_s   = 1'b0;
      gnt1_s   = 1'b0;
      arb_en_s = 1'b0;

      case (state_r)
         ST_INIT_RST: begin
            if (cnt_r == RST_LAST) begin
               // load the internal control-word write; INIT_CWR is its setup cycle
               state_s = ST_INIT_CWR;
               cnt_s   = CNT_ZERO;
               owner_s = OWN_INIT;
               we_s    = 1'b1;
               addr_s  = ADDR_CWR;
               wdata_s = INIT_CWR;
               skip_s  = 1'b0;
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         ST_INIT_CWR: begin
            state_s = ST_STROBE;
            cnt_s   = CNT_ZERO;
         end
         ST_IDLE: begin
            if (gnt0_r || gnt1_r) begin
               // grant cycle: fields already latched, start the access
               skip_s = skip_hit_s;
               if (skip_hit_s) begin
                  state_s = ST_HOLD;
               end else begin
                  state_s = ST_SETUP;
               end
            end else begin
               arb_en_s = 1'b1;
            end
         end
         ST_SETUP: begin
            state_s = ST_STROBE;
            cnt_s   = CNT_ZERO;
         end
         ST_STROBE: begin
            if (cnt_r == STROBE_LAST) begin
               state_s = ST_HOLD;
               if (!we_r) begin
                  rdata_s = bus.ppi_din;
               end else if (addr_r == ADDR_CWR) begin
                  shadow_s = wdata_r;
               end else begin
                  rdata_s = rdata_r;
               end
            end else begin
               cnt_s = cnt_r + 1'b1;
            end
         end
         ST_HOLD: begin
            state_s  = ST_IDLE;
            skip_s   = 1'b0;
            arb_en_s = 1'b1;
         end
         default: begin
            state_s = ST_INIT_RST;
            cnt_s   = CNT_ZERO;
         end
      endcase

      // a grant is issued whenever the next cycle is an IDLE cycle
      if (arb_en_s) begin
         if (pick0_s) begin
            gnt0_s  = 1'b1;
            owner_s = OWN_REQ0;
            we_s    = bus.we0;
            addr_s  = bus.addr0;
            wdata_s = bus.wdata0;
            rr_s    = 1'b1;
         end else if (pick1_s) begin
            gnt1_s  = 1'b1;
            owner_s = OWN_REQ1;
            we_s    = bus.we1;
            addr_s  = bus.addr1;
            wdata_s = bus.wdata1;
            rr_s    = 1'b0;
         end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      end else begin
         arb_en_s = 1'b0;
      end
   end

   // Pin and status decode from the next state so the flops line up with it.
   always_comb begin
      bus_act_s   = (state_s == ST_INIT_CWR) || (state_s == ST_SETUP) ||
                    (state_s == ST_STROBE)   || ((state_s == ST_HOLD) && !skip_s);
      csb_s       = ~bus_act_s;
      wrb_s       = ~((state_s == ST_STROBE) && we_s);
      rdb_s       = ~((state_s == ST_STROBE) && !we_s);
      doe_s       = bus_act_s && we_s;
      ppi_reset_s = (state_s == ST_INIT_RST);
      busy_s      = (state_s != ST_IDLE);
      done0_s     = (state_s == ST_HOLD) && (owner_s == OWN_REQ0);
      done1_s     = (state_s == ST_HOLD) && (owner_s == OWN_REQ1);
      if (bus_act_s) begin
         a_s = addr_s;
      end else begin
         a_s = 2'b00;
      end
      if (doe_s) begin
         dout_s = wdata_s;
      end else begin
         dout_s = 8'h00;
      end
   end

   // State, latched fields and all registered outputs.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_r     <= ST_INIT_RST;
         cnt_r       <= CNT_ZERO;
         owner_r     <= OWN_INIT;
         we_r        <= 1'b0;
         addr_r      <= 2'b00;
         wdata_r     <= 8'h00;
         skip_r      <= 1'b0;
         rr_r        <= 1'b0;
         rdata_r     <= 8'h00;
         shadow_r    <= INIT_CWR;
         gnt0_r      <= 1'b0;
         gnt1_r      <= 1'b0;
         done0_r     <= 1'b0;
         done1_r     <= 1'b0;
         busy_r      <= 1'b1;
         ppi_reset_r <= 1'b1;
         csb_r       <= 1'b1;
         wrb_r       <= 1'b1;
         rdb_r       <= 1'b1;
         a_r         <= 2'b00;
         dout_r      <= 8'h00;
         doe_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         owner_r     <= owner_s;
         we_r        <= we_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         skip_r      <= skip_s;
         rr_r        <= rr_s;
         rdata_r     <= rdata_s;
         shadow_r    <= shadow_s;
         gnt0_r      <= gnt0_s;
         gnt1_r      <= gnt1_s;
         done0_r     <= done0_s;
         done1_r     <= done1_s;
         busy_r      <= busy_s;
         ppi_reset_r <= ppi_reset_s;
         csb_r       <= csb_s;
         wrb_r       <= wrb_s;
         rdb_r       <= rdb_s;
         a_r         <= a_s;
         dout_r      <= dout_s;
         doe_r       <= doe_s;
      end
   end

   assign bus.gnt0       = gnt0_r;
   assign bus.gnt1       = gnt1_r;
   assign bus.done0      = done0_r;
   assign bus.done1      = done1_r;
   assign bus.rdata      = rdata_r;
   assign bus.busy       = busy_r;
   assign bus.cwr_shadow = shadow_r;
   assign bus.ppi_reset  = ppi_reset_r;
   assign bus.ppi_csb    = csb_r;
   assign bus.ppi_wrb    = wrb_r;
   assign bus.ppi_rdb    = rdb_r;
   assign bus.ppi_a1     = a_r[1];
   assign bus.ppi_a0     = a_r[0];
   assign bus.ppi_dout   = dout_r;
   assign bus.ppi_doe    = doe_r;

endmodule
